// File: rtl/midi_spi_pkg.sv
// Shared encodings and defaults for the MIDI-over-SPI transmitter and receiver.
package midi_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_e;

  localparam int SPI_BITS_PER_BYTE    = 8;
  localparam int SPI_CLK_DIV_DEFAULT  = 4;
  localparam int SPI_BYTE_GAP_DEFAULT = 8;

endpackage

// File: rtl/spi_midi_tx_fifo.sv
// Small synchronous FIFO feeding the SPI MIDI transmitter; DEPTH is a power of 2, >= 2.
module spi_midi_tx_fifo
  import midi_spi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = SPI_BITS_PER_BYTE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/spi_midi_tx.sv
// Mode-0, MSB-first SPI master sending MIDI bytes with a fixed idle gap between bytes.
// Define SPI_MIDI_TX_FIFO_EN to add a FIFO_DEPTH-entry input FIFO.
module spi_midi_tx
  import midi_spi_pkg::*;
#(
  parameter int CLK_DIV    = SPI_CLK_DIV_DEFAULT,
  parameter int BYTE_GAP   = SPI_BYTE_GAP_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       SPI_sclk,
  output logic       SPI_mosi,
  output logic       busy
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int GW = $clog2(BYTE_GAP + 1);
  localparam int BW = $clog2(SPI_BITS_PER_BYTE);

  tx_state_e                    state, state_nxt;
  logic [DW-1:0]                div_cnt, div_nxt;
  logic [GW-1:0]                gap_cnt, gap_nxt;
  logic [BW-1:0]                bit_cnt, bit_nxt;
  logic [SPI_BITS_PER_BYTE-1:0] shift, shift_nxt, load_byte;
  logic                         sclk, sclk_nxt;
  logic                         idle, start;

  assign idle = (state == ST_IDLE);

`ifdef SPI_MIDI_TX_FIFO_EN
  logic                         fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [SPI_BITS_PER_BYTE-1:0] fifo_dout;

  // A byte arriving while idle with nothing queued bypasses the FIFO so the
  // SPI timing matches the unbuffered build.
  assign tx_ready  = !reset && !fifo_full;
  assign fifo_pop  = idle && !fifo_empty;
  assign fifo_push = tx_valid && tx_ready && !(idle && fifo_empty);
  assign start     = idle && (!fifo_empty || (tx_valid && tx_ready));
  assign load_byte = fifo_empty ? tx_data : fifo_dout;
  assign busy      = !idle || !fifo_empty;

  spi_midi_tx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(SPI_BITS_PER_BYTE)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (tx_data),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );
`else
  logic unused_fifo_depth;

  assign tx_ready          = !reset && idle;
  assign start             = tx_valid && tx_ready;
  assign load_byte         = tx_data;
  assign busy              = !idle;
  assign unused_fifo_depth = (FIFO_DEPTH != 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      gap_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      sclk    <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      gap_cnt <= gap_nxt;
      bit_cnt <= bit_nxt;
      shift   <= shift_nxt;
      sclk    <= sclk_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    gap_nxt   = gap_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    sclk_nxt  = sclk;
    case (state)
      ST_IDLE: begin
        div_nxt  = '0;
        gap_nxt  = '0;
        bit_nxt  = '0;
        sclk_nxt = 1'b0;
        if (start) begin
          shift_nxt = load_byte;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (div_cnt == DW'(CLK_DIV - 1)) begin
          div_nxt  = '0;
          sclk_nxt = !sclk;
          if (!sclk) begin
            bit_nxt = bit_cnt + 1'b1;
          end else begin
            // The bit counter has wrapped to zero after the 8th rising edge.
            shift_nxt = shift << 1;
            if (bit_cnt == '0) state_nxt = ST_GAP;
          end
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GW'(BYTE_GAP - 1)) begin
          gap_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign SPI_sclk = sclk;
  assign SPI_mosi = (state == ST_SHIFT) && shift[SPI_BITS_PER_BYTE-1];

endmodule

// File: tb/tb_spi_midi_tx.sv
// Randomized bench for spi_midi_tx against a cycle-timing reference model of the SPI waveform.
module tb_spi_midi_tx;

  localparam int CD       = 4;
  localparam int BG       = 8;
  localparam int DEPTH    = 4;
  localparam int BYTE_LEN = 16 * CD + BG;
`ifdef SPI_MIDI_TX_FIFO_EN
  localparam int ACC_STEP = 1;
  localparam int HOLD6    = BYTE_LEN + 2;
`else
  localparam int ACC_STEP = BYTE_LEN + 1;
  localparam int HOLD6    = 5 * (BYTE_LEN + 1);
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, SPI_sclk, SPI_mosi, busy;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  int         q_start[$];
  logic [7:0] q_byte[$];
  logic [7:0] exp_bytes[$];
  int         last_start = -1000;
  logic       prev_sclk = 1'b0;
  logic       prev_mosi = 1'b0;
  logic [7:0] rx_sh = 8'h00;
  int         rx_bits = 0;

  spi_midi_tx #(.CLK_DIV(CD), .BYTE_GAP(BG), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .SPI_sclk(SPI_sclk),
    .SPI_mosi(SPI_mosi),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
    end
  endtask

  // Reference: byte k occupies [start, start+BYTE_LEN); start = max(accept+1, prev start + BYTE_LEN + 1).
  always @(negedge clk) begin
    int c, pend, t;
    logic e_sclk, e_mosi, e_busy, e_ready;
    logic [7:0] b;
    c = cyc;
    if (reset) begin
      check("rst_sclk", SPI_sclk, 0);
      check("rst_mosi", SPI_mosi, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", tx_ready, 0);
      q_start.delete(); q_byte.delete(); exp_bytes.delete();
      last_start = -1000; rx_bits = 0; prev_sclk = 1'b0; prev_mosi = 1'b0;
    end else begin
      while (q_start.size() > 0 && q_start[0] + BYTE_LEN <= c) begin
        void'(q_start.pop_front());
        void'(q_byte.pop_front());
      end
      e_sclk = 1'b0; e_mosi = 1'b0; pend = 0;
      e_busy = (q_start.size() != 0);
      foreach (q_start[i]) begin
        if (c < q_start[i]) pend++;
        else if (c - q_start[i] < 16 * CD) begin
          t = c - q_start[i];
          b = q_byte[i];
          e_sclk = ((t / CD) % 2) == 1;
          e_mosi = b[7 - t / (2 * CD)];
        end
      end
`ifdef SPI_MIDI_TX_FIFO_EN
      e_ready = (pend < DEPTH);
`else
      e_ready = !e_busy;
`endif
      check("sclk", SPI_sclk, e_sclk);
      check("mosi", SPI_mosi, e_mosi);
      check("busy", busy, e_busy);
      check("tx_ready", tx_ready, e_ready);
      if (!prev_sclk && SPI_sclk) begin
        check("mode0_hold", SPI_mosi, prev_mosi);
        rx_sh = {rx_sh[6:0], SPI_mosi};
        rx_bits++;
        if (rx_bits == 8) begin
          rx_bits = 0;
          check("rx_expected", exp_bytes.size() > 0, 1);
          if (exp_bytes.size() > 0) check("rx_byte", rx_sh, exp_bytes.pop_front());
        end
      end
      prev_sclk = SPI_sclk;
      prev_mosi = SPI_mosi;
      if (tx_valid && tx_ready) begin
        last_start = (c + 1 > last_start + BYTE_LEN + 1) ? c + 1 : last_start + BYTE_LEN + 1;
        q_start.push_back(last_start);
        q_byte.push_back(tx_data);
        exp_bytes.push_back(tx_data);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [7:0] b, output int acc);
    int n = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    acc = -1;
    while (acc < 0 && n < 2000) begin
      @(negedge clk);
      n++;
      if (tx_ready) acc = cyc;
    end
    check("push_accept", acc >= 0, 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || q_start.size() > 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", busy, 0);
    step(2);
  endtask

  initial begin
    int a, a1, a2, a3, n;
    int acc6[6];
    #1 reset = 1'b1;
    #1;
    check("arst_ready", tx_ready, 0);
    step(3);
    reset = 1'b0;
    step(2);

    // Single byte: first rise at N+5, ready again at N+73 without FIFO.
    push(8'h90, a);
    n = 0;
    do begin @(negedge clk); n++; end while (!SPI_sclk && n < 200);
    check("first_rise", cyc - a, 1 + CD);
`ifndef SPI_MIDI_TX_FIFO_EN
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_ready && n < 200);
    check("ready_again", cyc - a, BYTE_LEN + 1);
`endif
    @(posedge clk); #1;
    wait_idle();

    // tx_valid held across two bytes.
    push(8'h3C, a1);
    push(8'h7F, a2);
    check("b2b_accept", a2 - a1, ACC_STEP);
    wait_idle();

    // Three bytes offered on consecutive cycles.
    push(8'h90, a1);
    push(8'h3C, a2);
    push(8'h7F, a3);
    check("three_acc2", a3 - a1, 2 * ACC_STEP);
    wait_idle();

    // Six back-to-back offers: shift register plus FIFO fill, then the 6th waits for a pop.
    for (int i = 0; i < 6; i++) push(8'($urandom), acc6[i]);
    check("acc5", acc6[4] - acc6[0], 4 * ACC_STEP);
    check("hold6", acc6[5] - acc6[0], HOLD6);
    wait_idle();

    // Asynchronous reset at the 3rd rising edge of 0x55.
    push(8'h55, a);
    while (cyc < a + 1 + 5 * CD) step(1);
    check("rise3_sclk", SPI_sclk, 1);
    #1 reset = 1'b1;
    #1;
    check("arst_sclk", SPI_sclk, 0);
    check("arst_mosi", SPI_mosi, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", tx_ready, 0);
    step(2);
    reset = 1'b0;
    push(8'hAA, a);
    wait_idle();

    // Loopback bytes through the bench's own mode-0 deserializer.
    push(8'h80, a1);
    push(8'h40, a2);
    push(8'h00, a3);
    wait_idle();

    // Random bytes with random spacing, occasionally back-to-back.
    for (int k = 0; k < 24; k++) begin
      push(8'($urandom), a);
      if ($urandom_range(0, 3) != 0) step($urandom_range(0, 90));
    end
    wait_idle();
    check("rx_all_seen", exp_bytes.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_midi_tx.md
# spi_midi_tx

SPI master transmitter that serializes MIDI bytes onto a two-wire SPI link (`SPI_sclk`, `SPI_mosi`). It is the sending end of the synth's SPI input: the same mode-0, MSB-first, clock-plus-data-only framing that the synth's receiver samples. It sits in bench, loopback and host-bridge designs and feeds bytes from a valid/ready stream. There is no chip-select; byte framing relies on a fixed 8-bit length and an enforced idle gap.

## Interface

Parameters:
- `CLK_DIV`, default 4: `clk` cycles per SCLK half-period. Legal range is ≥ 2.
- `BYTE_GAP`, default 8: idle `clk` cycles with SCLK low after each byte. Legal range is ≥ 1.
- `FIFO_DEPTH`, default 4: input FIFO entries, power of 2. Used only when `SPI_MIDI_TX_FIFO_EN` is defined.

Ports:
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `tx_data` input, 8 bits: byte to send.
- `tx_valid` input, 1 bit: `tx_data` is valid.
- `tx_ready` output, 1 bit: block accepts a byte this cycle.
- `SPI_sclk` output, 1 bit: SPI clock. Idles low.
- `SPI_mosi` output, 1 bit: SPI data.
- `busy` output, 1 bit: a byte is in flight, or bytes are queued.

## Operation

- Handshake: a byte is accepted on a cycle where `tx_valid && tx_ready`. `tx_data` is sampled only on that cycle.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - `SPI_sclk` = 0 and `SPI_mosi` = 0.
  - If a byte is available, it loads into an 8-bit shift register and the block goes to SHIFT.
- SHIFT:
  - A half-period counter runs 0..`CLK_DIV`-1. `SPI_sclk` toggles when the counter wraps.
  - `SPI_mosi` = shift[7] while in SHIFT.
  - On each SCLK falling edge the register shifts left by one.
  - A 3-bit bit counter counts rising edges.
  - After the 8th falling edge the block goes to GAP.
- GAP:
  - Lasts exactly `BYTE_GAP` cycles, with `SPI_sclk` = 0 and `SPI_mosi` = 0.
  - Then goes to IDLE. A queued byte starts on the following cycle.
- Mode 0: data is stable across every SCLK rising edge. Data changes only with or after a falling edge.
- Without FIFO:
  - `tx_ready` = (state == IDLE).
  - `busy` = (state != IDLE).
- With FIFO:
  - `tx_ready` = !fifo_full. Bytes can be accepted in any state.
  - A byte accepted while empty in IDLE starts on the next cycle, identical to the non-FIFO case.
  - `busy` = (state != IDLE) || !fifo_empty.
  - Simultaneous push and pop on a full FIFO is not allowed: `tx_ready` is already low.
- Reset, asynchronous, including mid-byte:
  - State = IDLE; counters, shift register and FIFO pointers cleared.
  - `SPI_sclk` = 0, `SPI_mosi` = 0, `busy` = 0.
  - `tx_ready` = 0 while `reset` is high and 1 on the first cycle after release.
  - A partial byte is dropped and never resumed. Downstream resynchronization relies on the receiver's own reset.

## Timing

Cycle timings are measured from handshake cycle N:
- N+1: SHIFT entered, `SPI_mosi` = bit 7, `SPI_sclk` = 0.
- Rising edge k (k = 1..8) is at N+1+(2k−1)·`CLK_DIV`.
- Falling edge k is at N+1+2k·`CLK_DIV`.
- GAP occupies N+1+16·`CLK_DIV` through N+16·`CLK_DIV`+`BYTE_GAP`.
- IDLE, with `tx_ready` = 1 (no FIFO), at N+1+16·`CLK_DIV`+`BYTE_GAP`.
- Throughput is one byte per 16·`CLK_DIV`+`BYTE_GAP`+1 cycles.
- All outputs are registered. No combinational path from inputs to `SPI_*`.

## Configuration

- `SPI_MIDI_TX_FIFO_EN` defined: a `FIFO_DEPTH`-entry input FIFO is instantiated, and `tx_ready`/`busy` follow the FIFO rules above.
- `SPI_MIDI_TX_FIFO_EN` not defined: a single shift register only; `tx_ready` is high only in IDLE.
- SPI waveform timing is identical either way.

## Structure

- Package `midi_spi_pkg`:
  - State encoding (IDLE/SHIFT/GAP).
  - `SPI_BITS_PER_BYTE` = 8.
  - Default `CLK_DIV`/`BYTE_GAP` constants, shared with the receiver.
- Sub-module `spi_midi_tx_fifo`:
  - Synchronous FIFO with `clk` and `reset`.
  - push/pop/full/empty/dout.
  - Instantiated only under `SPI_MIDI_TX_FIFO_EN`.

## Test plan

All scenarios use `CLK_DIV`=4 and `BYTE_GAP`=8.

1. Send 0x90 → MOSI sampled at the 8 SCLK rising edges = 1,0,0,1,0,0,0,0; first rise at N+5; `tx_ready` high again at N+73 (no FIFO).
2. Hold `tx_valid` high with 0x3C, then 0x7F, no FIFO → exactly two 8-edge bursts; ≥8 idle SCLK-low cycles between them; second byte accepted at N+73.
3. FIFO enabled, push 0x90, 0x3C, 0x7F on consecutive cycles → all accepted with `tx_ready`=1; three bytes sent in order; `busy` falls after the last GAP.
4. FIFO enabled, 6 back-to-back pushes during the first byte → `tx_ready` drops after the 5th accept (one byte in shift register plus 4 queued); the 6th is held until a pop occurs.
5. Assert `reset` at the 3rd rising edge of 0x55 → `SPI_sclk`=0, `SPI_mosi`=0, `busy`=0 immediately (asynchronous); after release, 0xAA sends cleanly with no residual 0x55 bits.
6. Receiver loopback: bytes 0x80 0x40 0x00 into the synth's SPI receiver → the receiver reports the same three bytes.
